// File: rtl/rp_asg_arb_pkg.sv
// Purpose: shared constants for the ASG AXI read arbiter (FSM states, AXI read size, default sizes).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rp_asg_arb_pkg;

    localparam int         NCH_DEF   = 2;
    localparam int         LW_DEF    = 4;
    localparam logic [2:0] RSIZE_DEF = 3'h3;   // 8-byte beats

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/rp_rr_arb.sv
// Purpose: round-robin picker; first eligible channel searching upward from rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is consumed.
//
// Ports: eligible (per-channel request), rr_ptr (search start), winner (one-hot), win_any (some winner).
module rp_rr_arb
    import rp_asg_arb_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] eligible,
    input  logic [PW-1:0]  rr_ptr,
    output logic [NCH-1:0] winner,
    output logic           win_any
);

    int idx;

    always_comb begin
        winner  = '0;
        win_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (!win_any && eligible[idx]) begin
                winner[idx] = 1'b1;
                win_any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rp_asg_axi_arb.sv
// Purpose: shares one AXI read-burst engine between NCH ASG channels, routing returned beats to the owner.
// Latency: request accepted same cycle (IDLE), engine pulse next cycle, beats pass through combinationally.
// Backpressure: owner's ch_drdy_i gates rd_drdy_o; a flushed owner or stray beat is always accepted and dropped.
//
// Ports: req_* (per-channel burst requests), ch_clr_i (flush), ctrl_* (engine command), rd_* (engine beats),
//        ch_* (beat broadcast + owner valid), grant_o (owner), drop_cnt_o / err_o (discard status).
module rp_asg_axi_arb
    import rp_asg_arb_pkg::*;
#(
    parameter int         NCH   = NCH_DEF,
    parameter int         AW    = 32,
    parameter int         DW    = 64,
    parameter int         LW    = LW_DEF,
    parameter logic [2:0] RSIZE = RSIZE_DEF
) (
    input  logic              axi_clk_i,
    input  logic              axi_rst_i,
    input  logic [NCH-1:0]    req_val_i,
    input  logic [NCH*AW-1:0] req_addr_i,
    input  logic [NCH*LW-1:0] req_len_i,
    output logic [NCH-1:0]    req_rdy_o,
    input  logic [NCH-1:0]    ch_clr_i,
    output logic [AW-1:0]     ctrl_addr_o,
    output logic [LW-1:0]     ctrl_size_o,
    output logic [2:0]        ctrl_rsize_o,
    output logic              ctrl_val_o,
    input  logic              ctrl_busy_i,
    input  logic [DW-1:0]     rd_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    input  logic              rd_dval_i,
    output logic              rd_drdy_o,
    output logic [DW-1:0]     ch_data_o,
    output logic [AW-1:0]     ch_addr_o,
    output logic [NCH-1:0]    ch_dval_o,
    input  logic [NCH-1:0]    ch_drdy_i,
    output logic [NCH-1:0]    grant_o,
    output logic [15:0]       drop_cnt_o,
    output logic              err_o
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [1:0]     state;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  owner;
    logic [AW-1:0]  addr_q;
    logic [LW-1:0]  len_q;
    logic [LW-1:0]  beat_cnt;
    logic           drain;

    logic [NCH-1:0] winner;
    logic           win_any;
    logic [PW-1:0]  win_idx;
    logic           in_idle;
    logic           in_xfer;
    logic           owner_clr;
    logic           drop_now;
    logic           beat_take;
    logic           discard;
    logic           stray;

    rp_rr_arb #(.NCH(NCH), .PW(PW)) u_rr (
        .eligible (req_val_i & ~ch_clr_i),
        .rr_ptr   (rr_ptr),
        .winner   (winner),
        .win_any  (win_any)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (winner[i]) win_idx = PW'(i);
        end
    end

    assign in_idle   = (state == ST_IDLE);
    assign in_xfer   = (state == ST_XFER);
    assign owner_clr = ch_clr_i[owner];
    // A flush arriving with a beat drops that beat too, so the same-cycle clear is folded in.
    assign drop_now  = drain | owner_clr;
    assign stray     = rd_dval_i & ~in_xfer;
    // Outside XFER any beat is a stray; accept it so the engine cannot stall on it.
    assign rd_drdy_o = in_xfer ? (drop_now | ch_drdy_i[owner]) : rd_dval_i;
    assign beat_take = in_xfer & rd_dval_i & rd_drdy_o;
    assign discard   = (beat_take & drop_now) | stray;

    assign req_rdy_o    = (in_idle && !axi_rst_i) ? winner : '0;
    assign ctrl_val_o   = (state == ST_ISSUE);
    assign ctrl_addr_o  = addr_q;
    assign ctrl_size_o  = len_q;
    assign ctrl_rsize_o = RSIZE;
    assign ch_data_o    = in_xfer ? rd_data_i : '0;
    assign ch_addr_o    = in_xfer ? rd_addr_i : '0;
    assign ch_dval_o    = (in_xfer && rd_dval_i && !drop_now) ? grant_o : '0;

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            grant_o    <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            drain      <= 1'b0;
            drop_cnt_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (discard && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
            if (stray) err_o <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        owner   <= win_idx;
                        grant_o <= winner;
                        addr_q  <= req_addr_i[int'(win_idx)*AW +: AW];
                        len_q   <= req_len_i[int'(win_idx)*LW +: LW];
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (owner_clr) drain <= 1'b1;
                    state <= ST_XFER;
                end
                ST_XFER: begin
                    if (owner_clr) drain <= 1'b1;
                    if (beat_take) begin
                        if (beat_cnt == len_q) begin
                            beat_cnt <= '0;
                            state    <= ST_DONE;
                        end else begin
                            beat_cnt <= beat_cnt + LW'(1);
                        end
                    end
                end
                default: begin
                    // Hold ownership until the engine has fully retired the burst.
                    if (!ctrl_busy_i) begin
                        state   <= ST_IDLE;
                        rr_ptr  <= (int'(owner) == NCH-1) ? '0 : owner + PW'(1);
                        grant_o <= '0;
                        drain   <= 1'b0;
                        addr_q  <= '0;
                        len_q   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rp_asg_axi_arb.sv
// Purpose: scoreboard bench for rp_asg_axi_arb with a behavioural read-burst engine.
// Latency: n/a.
// Backpressure: per-channel ch_drdy_i driven by the directed tests.
module tb_rp_asg_axi_arb;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int LW  = 4;

    logic              axi_clk_i = 1'b0;
    logic              axi_rst_i;
    logic [NCH-1:0]    req_val_i;
    logic [NCH*AW-1:0] req_addr_i;
    logic [NCH*LW-1:0] req_len_i;
    logic [NCH-1:0]    req_rdy_o;
    logic [NCH-1:0]    ch_clr_i;
    logic [AW-1:0]     ctrl_addr_o;
    logic [LW-1:0]     ctrl_size_o;
    logic [2:0]        ctrl_rsize_o;
    logic              ctrl_val_o;
    logic              ctrl_busy_i;
    logic [DW-1:0]     rd_data_i;
    logic [AW-1:0]     rd_addr_i;
    logic              rd_dval_i;
    logic              rd_drdy_o;
    logic [DW-1:0]     ch_data_o;
    logic [AW-1:0]     ch_addr_o;
    logic [NCH-1:0]    ch_dval_o;
    logic [NCH-1:0]    ch_drdy_i;
    logic [NCH-1:0]    grant_o;
    logic [15:0]       drop_cnt_o;
    logic              err_o;

    rp_asg_axi_arb #(.NCH(NCH), .AW(AW), .DW(DW), .LW(LW), .RSIZE(3'h3)) dut (
        .axi_clk_i    (axi_clk_i),
        .axi_rst_i    (axi_rst_i),
        .req_val_i    (req_val_i),
        .req_addr_i   (req_addr_i),
        .req_len_i    (req_len_i),
        .req_rdy_o    (req_rdy_o),
        .ch_clr_i     (ch_clr_i),
        .ctrl_addr_o  (ctrl_addr_o),
        .ctrl_size_o  (ctrl_size_o),
        .ctrl_rsize_o (ctrl_rsize_o),
        .ctrl_val_o   (ctrl_val_o),
        .ctrl_busy_i  (ctrl_busy_i),
        .rd_data_i    (rd_data_i),
        .rd_addr_i    (rd_addr_i),
        .rd_dval_i    (rd_dval_i),
        .rd_drdy_o    (rd_drdy_o),
        .ch_data_o    (ch_data_o),
        .ch_addr_o    (ch_addr_o),
        .ch_dval_o    (ch_dval_o),
        .ch_drdy_i    (ch_drdy_i),
        .grant_o      (grant_o),
        .drop_cnt_o   (drop_cnt_o),
        .err_o        (err_o)
    );

    always #5 axi_clk_i = ~axi_clk_i;

    typedef struct { int ch; logic [AW-1:0] addr; logic [LW-1:0] len; } ctrl_exp_t;
    typedef struct { int ch; logic [DW-1:0] dat; logic [AW-1:0] addr; } beat_exp_t;

    ctrl_exp_t exp_ctrl[$];
    beat_exp_t exp_beat[$];
    int        n_vec = 0;
    int        n_bad = 0;
    int        del_cnt[NCH];
    int        stray_req = 0;
    int        stray_done = 0;

    function automatic logic [DW-1:0] beat_dat(input logic [AW-1:0] a, input int k);
        return {a, 32'(k)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    task automatic expect_burst(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] len, input int keep);
        exp_ctrl.push_back('{ch, a, len});
        for (int k = 0; k < keep; k++) exp_beat.push_back('{ch, beat_dat(a, k), a + AW'(8*k)});
    endtask

    task automatic tick();
        @(posedge axi_clk_i);
        #1;
    endtask

    task automatic issue(input int c, input logic [AW-1:0] a, input logic [LW-1:0] len,
                         output logic [NCH-1:0] first_rdy);
        int t;
        tick();
        req_val_i[c]             = 1'b1;
        req_addr_i[c*AW +: AW]   = a;
        req_len_i[c*LW +: LW]    = len;
        @(negedge axi_clk_i);
        first_rdy = req_rdy_o;
        t = 0;
        while (!req_rdy_o[c] && t < 200) begin
            @(negedge axi_clk_i);
            t++;
        end
        if (t >= 200) fail_now("issue_timeout");
        tick();
        req_val_i[c] = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((grant_o != '0 || ctrl_busy_i) && t < 400) begin
            @(negedge axi_clk_i);
            t++;
        end
        if (t >= 400) fail_now(nm);
        tick();
    endtask

    task automatic wait_deliv(input int c, input int n);
        int cnt;
        int t;
        cnt = 0;
        t   = 0;
        while (cnt < n && t < 200) begin
            @(negedge axi_clk_i);
            if (ch_dval_o[c] && ch_drdy_i[c]) cnt++;
            t++;
        end
        if (t >= 200) fail_now("deliv_timeout");
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT issues a command or delivers a beat.
    initial begin
        ctrl_exp_t ce;
        beat_exp_t be;
        for (int i = 0; i < NCH; i++) del_cnt[i] = 0;
        forever begin
            @(negedge axi_clk_i);
            if (ctrl_val_o) begin
                chk("ctrl_overlap_busy", ctrl_busy_i, 0);
                if (exp_ctrl.size() == 0) fail_now("ctrl_unexpected");
                else begin
                    ce = exp_ctrl.pop_front();
                    chk("ctrl_grant", grant_o, 64'(1) << ce.ch);
                    chk("ctrl_addr", ctrl_addr_o, ce.addr);
                    chk("ctrl_size", ctrl_size_o, ce.len);
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (ch_dval_o[i] && ch_drdy_i[i]) begin
                    del_cnt[i]++;
                    if (exp_beat.size() == 0) fail_now("beat_unexpected");
                    else begin
                        be = exp_beat.pop_front();
                        chk("beat_ch", i, be.ch);
                        chk("beat_data", ch_data_o, be.dat);
                        chk("beat_addr", ch_addr_o, be.addr);
                    end
                end
            end
        end
    end

    // Behavioural read-burst engine: beats start the cycle after ctrl_val_o, busy tail of 2 cycles.
    initial begin
        logic [AW-1:0] e_base;
        logic [AW-1:0] ca;
        logic [LW-1:0] cs;
        int  e_n, e_k, e_tail;
        bit  e_beats, e_stray, take_s, cv, rs;
        e_base = '0; e_n = 0; e_k = 0; e_tail = 0; e_beats = 0; e_stray = 0;
        rd_dval_i = 1'b0; rd_data_i = '0; rd_addr_i = '0; ctrl_busy_i = 1'b0;
        forever begin
            @(negedge axi_clk_i);
            take_s = rd_dval_i & rd_drdy_o;
            cv     = ctrl_val_o;
            ca     = ctrl_addr_o;
            cs     = ctrl_size_o;
            rs     = axi_rst_i;
            tick();
            if (rs) begin
                e_beats = 0; e_stray = 0; e_tail = 0;
                rd_dval_i = 1'b0; ctrl_busy_i = 1'b0;
                stray_done = stray_req;
            end else if (e_stray) begin
                rd_dval_i = 1'b0;
                e_stray   = 0;
                stray_done++;
            end else if (e_tail > 0) begin
                e_tail--;
                if (e_tail == 0) ctrl_busy_i = 1'b0;
            end else if (e_beats) begin
                if (take_s) begin
                    e_k++;
                    if (e_k == e_n) begin
                        e_beats   = 0;
                        rd_dval_i = 1'b0;
                        e_tail    = 2;
                    end else begin
                        rd_data_i = beat_dat(e_base, e_k);
                        rd_addr_i = e_base + AW'(8*e_k);
                    end
                end
            end else if (cv) begin
                ctrl_busy_i = 1'b1;
                e_base = ca; e_n = int'(cs) + 1; e_k = 0; e_beats = 1;
                rd_dval_i = 1'b1;
                rd_data_i = beat_dat(ca, 0);
                rd_addr_i = ca;
            end else if (stray_req != stray_done && !ctrl_busy_i) begin
                rd_dval_i = 1'b1;
                rd_data_i = 64'hDEAD_BEEF;
                rd_addr_i = '0;
                e_stray   = 1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] r;
        logic [NCH-1:0] acc;
        logic [NCH-1:0] exp_ord[4];
        int n0;
        int t;
        exp_ord[0] = 2'b01; exp_ord[1] = 2'b10; exp_ord[2] = 2'b01; exp_ord[3] = 2'b10;
        axi_rst_i = 1'b1; req_val_i = '0; req_addr_i = '0; req_len_i = '0;
        ch_clr_i = '0; ch_drdy_i = 2'b11;
        tick(); tick();
        @(negedge axi_clk_i);
        chk("rst_grant", grant_o, 0);
        chk("rst_ctrl_val", ctrl_val_o, 0);
        chk("rst_rsize", ctrl_rsize_o, 3'h3);
        chk("rst_req_rdy", req_rdy_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("rst_err", err_o, 0);
        tick();
        axi_rst_i = 1'b0;

        // T1: single ch0 burst of 16 beats
        expect_burst(0, 32'h1000_0000, 4'hF, 16);
        issue(0, 32'h1000_0000, 4'hF, r);
        chk("t1_req_rdy", r, 2'b01);
        @(negedge axi_clk_i);
        chk("t1_ctrl_val_pulse", ctrl_val_o, 1);
        @(negedge axi_clk_i);
        chk("t1_ctrl_val_once", ctrl_val_o, 0);
        wait_idle("t1_idle_timeout");
        chk("t1_beats", del_cnt[0], 16);
        chk("t1_grant_idle", grant_o, 0);

        // T2: both channels continuously from reset -> ch0, ch1, ch0, ch1
        tick(); axi_rst_i = 1'b1; tick(); tick(); axi_rst_i = 1'b0;
        expect_burst(0, 32'h1100_0000, 4'hF, 16);
        expect_burst(1, 32'h2100_0000, 4'h7, 8);
        expect_burst(0, 32'h1200_0000, 4'h3, 4);
        expect_burst(1, 32'h2200_0000, 4'h1, 2);
        req_addr_i = {32'h2100_0000, 32'h1100_0000};
        req_len_i  = {4'h7, 4'hF};
        req_val_i  = 2'b11;
        n0 = 0;
        for (int n = 0; n < 4; n++) begin
            t = 0;
            do begin
                @(negedge axi_clk_i);
                t++;
            end while (req_rdy_o == '0 && t < 300);
            if (t >= 300) begin
                fail_now("t2_grant_timeout");
                break;
            end
            acc = req_rdy_o;
            chk("t2_order", acc, exp_ord[n]);
            tick();
            if (acc[0]) begin
                n0++;
                if (n0 == 2) req_val_i[0] = 1'b0;
                else begin
                    req_addr_i[31:0] = 32'h1200_0000;
                    req_len_i[3:0]   = 4'h3;
                end
            end else if (n == 3) begin
                req_val_i[1] = 1'b0;
            end else begin
                req_addr_i[63:32] = 32'h2200_0000;
                req_len_i[7:4]    = 4'h1;
            end
        end
        req_val_i = '0;
        wait_idle("t2_idle_timeout");

        // T3: ch1 burst with 5 cycles of channel backpressure after 5 beats
        expect_burst(1, 32'h2000_0000, 4'hF, 16);
        issue(1, 32'h2000_0000, 4'hF, r);
        wait_deliv(1, 5);
        tick();
        ch_drdy_i[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge axi_clk_i);
            chk("t3_rd_drdy_low", rd_drdy_o, 0);
            chk("t3_beat_held", ch_dval_o[1], 1);
        end
        tick();
        ch_drdy_i[1] = 1'b1;
        wait_idle("t3_idle_timeout");
        chk("t3_drop", drop_cnt_o, 0);

        // T4: flush ch0 after 4 beats of 16
        expect_burst(0, 32'h3000_0000, 4'hF, 4);
        issue(0, 32'h3000_0000, 4'hF, r);
        wait_deliv(0, 4);
        tick();
        ch_clr_i[0] = 1'b1;
        tick();
        ch_clr_i[0] = 1'b0;
        wait_idle("t4_idle_timeout");
        chk("t4_drop", drop_cnt_o, 12);
        chk("t4_grant_idle", grant_o, 0);

        // T5: stray beat while idle
        stray_req++;
        t = 0;
        do begin
            @(negedge axi_clk_i);
            t++;
        end while (!rd_dval_i && t < 50);
        if (t >= 50) fail_now("t5_stray_timeout");
        chk("t5_stray_rdy", rd_drdy_o, 1);
        chk("t5_no_ch_dval", ch_dval_o, 0);
        tick();
        @(negedge axi_clk_i);
        chk("t5_err", err_o, 1);
        chk("t5_drop", drop_cnt_o, 13);
        tick(); tick(); tick();
        @(negedge axi_clk_i);
        chk("t5_err_sticky", err_o, 1);

        // T6: reset mid-burst after 7 beats, then a normal ch1 burst
        expect_burst(0, 32'h4000_0000, 4'hF, 7);
        issue(0, 32'h4000_0000, 4'hF, r);
        wait_deliv(0, 7);
        tick();
        axi_rst_i = 1'b1;
        ch_drdy_i = 2'b00;
        tick();
        @(negedge axi_clk_i);
        chk("t6_req_rdy", req_rdy_o, 0);
        chk("t6_ctrl_val", ctrl_val_o, 0);
        chk("t6_ctrl_addr", ctrl_addr_o, 0);
        chk("t6_ctrl_size", ctrl_size_o, 0);
        chk("t6_rsize", ctrl_rsize_o, 3'h3);
        chk("t6_rd_drdy", rd_drdy_o, 0);
        chk("t6_ch_dval", ch_dval_o, 0);
        chk("t6_grant", grant_o, 0);
        chk("t6_drop", drop_cnt_o, 0);
        chk("t6_err", err_o, 0);
        tick();
        axi_rst_i = 1'b0;
        ch_drdy_i = 2'b11;
        expect_burst(1, 32'h5000_0000, 4'h3, 4);
        issue(1, 32'h5000_0000, 4'h3, r);
        chk("t6_ch1_req_rdy", r, 2'b10);
        wait_idle("t6_idle_timeout");

        chk("sb_beats_left", exp_beat.size(), 0);
        chk("sb_ctrl_left", exp_ctrl.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
